// File: rtl/posit_addsub_raw_pipe.sv
// Four-stage raw posit adder/subtractor with valid/ready flow control and tag passthrough.
// Operands are pre-extracted {sgn, scale, fraction, inf, zero}; the result is unrounded.
module posit_addsub_raw_pipe #(
  parameter int SW    = 8,
  parameter int FW    = 27,
  parameter int GUARD = 3,
  parameter int TAG_W = 4,
  parameter int IN_W  = 1 + SW + FW + 2,
  parameter int OUT_W = 1 + SW + (FW + GUARD + 1) + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int MW   = FW + GUARD + 1;
  localparam int SUMW = MW + 1;
  localparam int SHW  = $clog2(MW + 1);
  localparam int PW   = $clog2(SUMW);
  localparam logic signed [SW:0]   MW_S     = (SW+1)'(MW);
  localparam logic signed [SW+1:0] NORM_OFS = (SW+2)'(FW + GUARD);
  localparam logic signed [SW+1:0] SCL_MAX  = (SW+2)'((1 << (SW-1)) - 1);
  localparam logic signed [SW+1:0] SCL_MIN  = -(SW+2)'(1 << (SW-1));

  function automatic logic [PW-1:0] lod(input logic [SUMW-1:0] v);
    lod = '0;
    for (int i = 0; i < SUMW; i++)
      if (v[i]) lod = PW'(i);
  endfunction

  function automatic logic signed [SW-1:0] sat_scale(input logic signed [SW+1:0] s);
    if (s > SCL_MAX)      sat_scale = SCL_MAX[SW-1:0];
    else if (s < SCL_MIN) sat_scale = SCL_MIN[SW-1:0];
    else                  sat_scale = s[SW-1:0];
  endfunction

  logic vld_p0, vld_p1, vld_p2, vld_p3;
  logic en_p0, en_p1, en_p2, en_p3;

  assign en_p3     = ~vld_p3 | out_ready;
  assign en_p2     = ~vld_p2 | en_p3;
  assign en_p1     = ~vld_p1 | en_p2;
  assign en_p0     = ~vld_p0 | en_p1;
  assign in_ready  = en_p0;
  assign out_valid = vld_p3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      if (en_p0) vld_p0 <= in_valid;
      if (en_p1) vld_p1 <= vld_p0;
      if (en_p2) vld_p2 <= vld_p1;
      if (en_p3) vld_p3 <= vld_p2;
    end
  end

  // Stage 0: capture, zero operands canonicalised, B sign folded with op_sub
  logic                 sgn_a_p0, sgn_b_p0, inf_a_p0, inf_b_p0, zro_a_p0, zro_b_p0;
  logic signed [SW-1:0] scl_a_p0, scl_b_p0;
  logic [FW-1:0]        frc_a_p0, frc_b_p0;
  logic [TAG_W-1:0]     tag_p0;

  always_ff @(posedge clk) begin
    if (en_p0) begin
      zro_a_p0 <= in1[0];
      inf_a_p0 <= in1[1] & ~in1[0];
      frc_a_p0 <= in1[0] ? '0 : in1[FW+1:2];
      scl_a_p0 <= in1[0] ? '0 : in1[FW+SW+1:FW+2];
      sgn_a_p0 <= ~in1[0] & in1[IN_W-1];
      zro_b_p0 <= in2[0];
      inf_b_p0 <= in2[1] & ~in2[0];
      frc_b_p0 <= in2[0] ? '0 : in2[FW+1:2];
      scl_b_p0 <= in2[0] ? '0 : in2[FW+SW+1:FW+2];
      sgn_b_p0 <= ~in2[0] & (in2[IN_W-1] ^ op_sub);
      tag_p0   <= in_tag;
    end
  end

  logic                 a_hi;
  logic signed [SW-1:0] hi_scl, lo_scl;
  logic [MW-1:0]        man_a, man_b;
  logic signed [SW:0]   diff;
  logic [SHW-1:0]       shamt;

  always_comb begin
    if (zro_b_p0)                   a_hi = 1'b1;
    else if (zro_a_p0)              a_hi = 1'b0;
    else if (scl_a_p0 != scl_b_p0)  a_hi = scl_a_p0 > scl_b_p0;
    else                            a_hi = frc_a_p0 >= frc_b_p0;
    man_a  = {~zro_a_p0, frc_a_p0, {GUARD{1'b0}}};
    man_b  = {~zro_b_p0, frc_b_p0, {GUARD{1'b0}}};
    hi_scl = a_hi ? scl_a_p0 : scl_b_p0;
    lo_scl = a_hi ? scl_b_p0 : scl_a_p0;
    diff   = (SW+1)'(hi_scl) - (SW+1)'(lo_scl);
    // A zero low operand has scale 0 and can exceed hi; its mantissa is empty anyway
    if (diff < 0)         shamt = '0;
    else if (diff > MW_S) shamt = SHW'(MW);
    else                  shamt = SHW'(diff);
  end

  // Stage 1: ordered operands and alignment distance
  logic [MW-1:0]        hi_man_p1, lo_man_p1;
  logic [SHW-1:0]       shamt_p1;
  logic                 sub_p1, hi_sgn_p1, inf_p1;
  logic signed [SW-1:0] hi_scl_p1;
  logic [TAG_W-1:0]     tag_p1;

  always_ff @(posedge clk) begin
    if (en_p1) begin
      hi_man_p1 <= a_hi ? man_a : man_b;
      lo_man_p1 <= a_hi ? man_b : man_a;
      shamt_p1  <= shamt;
      sub_p1    <= sgn_a_p0 ^ sgn_b_p0;
      hi_sgn_p1 <= a_hi ? sgn_a_p0 : sgn_b_p0;
      hi_scl_p1 <= hi_scl;
      inf_p1    <= inf_a_p0 | inf_b_p0;
      tag_p1    <= tag_p0;
    end
  end

  logic [MW-1:0]   lo_shift, lo_mask, lo_algn;
  logic [SUMW-1:0] raw_sum;

  always_comb begin
    lo_shift = lo_man_p1 >> shamt_p1;
    lo_mask  = ~({MW{1'b1}} << shamt_p1);
    lo_algn  = lo_shift | {{(MW-1){1'b0}}, |(lo_man_p1 & lo_mask)};
    raw_sum  = sub_p1 ? ({1'b0, hi_man_p1} - {1'b0, lo_algn})
                      : ({1'b0, hi_man_p1} + {1'b0, lo_algn});
  end

  // Stage 2: raw sum awaiting normalisation
  logic [SUMW-1:0]      sum_p2;
  logic                 hi_sgn_p2, inf_p2;
  logic signed [SW-1:0] hi_scl_p2;
  logic [TAG_W-1:0]     tag_p2;

  always_ff @(posedge clk) begin
    if (en_p2) begin
      sum_p2    <= raw_sum;
      hi_sgn_p2 <= hi_sgn_p1;
      hi_scl_p2 <= hi_scl_p1;
      inf_p2    <= inf_p1;
      tag_p2    <= tag_p1;
    end
  end

  logic [PW-1:0]        lead, lsh;
  logic signed [SW+1:0] scl_wide;
  logic [MW-1:0]        frc_norm;
  logic [OUT_W-1:0]     res_nx;

  always_comb begin
    lead     = lod(sum_p2);
    lsh      = PW'(SUMW - 1) - lead;
    scl_wide = (SW+2)'(hi_scl_p2) + $signed((SW+2)'(lead)) - NORM_OFS;
    frc_norm = MW'(sum_p2 << lsh);
    if (inf_p2)              res_nx = {{(OUT_W-2){1'b0}}, 2'b10};
    else if (sum_p2 == '0)   res_nx = {{(OUT_W-1){1'b0}}, 1'b1};
    else                     res_nx = {hi_sgn_p2, sat_scale(scl_wide), frc_norm, 2'b00};
  end

  // Stage 3: output register, cleared on reset so no stale result is visible
  logic [OUT_W-1:0] result_p3;
  logic [TAG_W-1:0] tag_p3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_p3 <= '0;
      tag_p3    <= '0;
    end else if (en_p3) begin
      result_p3 <= res_nx;
      tag_p3    <= tag_p2;
    end
  end

  assign result  = result_p3;
  assign out_tag = tag_p3;

endmodule
